// File: rtl/result_writeback.sv
// result_writeback
// Downstream stage of the 16x16 vector multiplier. Captures each result
// vector on res_valid into a small FIFO and drains it into the result SRAM
// at sequential addresses from a programmed base, with a ready handshake.
// Pulses done once the programmed number of rows has been committed.
//
// Ports:
//   clk, rstn          clock (rising edge), asynchronous active-low reset
//   start              begin a transfer (honoured in IDLE only)
//   base_addr          first SRAM address, sampled on start
//   num_rows           rows to write, sampled on start
//   res_valid/res_data result vector from the multiplier
//   sram_ready         SRAM accepts a write this cycle
//   sram_we/addr/wdata SRAM write request, address and data (FIFO head)
//   busy               high while in RUN
//   done               one-cycle completion pulse
//   overflow           sticky: a result was dropped on a full FIFO
//   rows_written       rows committed in the current or last transfer
module result_writeback #(
    parameter int ADDRESSSIZE    = 10,
    parameter int MATRIX_SIZE    = 16,
    parameter int PARTIAL_SUM_BW = 24,
    parameter int FIFO_DEPTH     = 4,
    parameter int ROWCNT_BW      = 11
) (
    input  logic                                  clk,
    input  logic                                  rstn,
    input  logic                                  start,
    input  logic [ADDRESSSIZE-1:0]                base_addr,
    input  logic [ROWCNT_BW-1:0]                  num_rows,
    input  logic                                  res_valid,
    input  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] res_data,
    input  logic                                  sram_ready,
    output logic                                  sram_we,
    output logic [ADDRESSSIZE-1:0]                sram_addr,
    output logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] sram_wdata,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  overflow,
    output logic [ROWCNT_BW-1:0]                  rows_written
);

    localparam int DATA_W = PARTIAL_SUM_BW * MATRIX_SIZE;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int SUM_W  = (ADDRESSSIZE > ROWCNT_BW) ? ADDRESSSIZE : ROWCNT_BW;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    state_t                 state, state_next;
    logic [ADDRESSSIZE-1:0] base_q;
    logic [ROWCNT_BW-1:0]   num_q;
    logic [ROWCNT_BW-1:0]   rows_in;
    logic [DATA_W-1:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr, rd_ptr;
    logic [PTR_W:0]         count;

    logic                   fifo_empty, fifo_full;
    logic                   start_ok, push_req, push, pop, drop;
    logic [SUM_W-1:0]       addr_sum;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_next;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (start) state_next = (num_rows == '0) ? FIN : RUN;
            RUN:  if (pop && (rows_written + ROWCNT_BW'(1) == num_q)) state_next = FIN;
            FIN:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------- FSM: outputs and handshake decode ----------------
    always_comb begin
        fifo_empty = (count == '0);
        fifo_full  = (count == (PTR_W+1)'(FIFO_DEPTH));
        busy       = (state == RUN);
        done       = (state == FIN);
        sram_we    = (state == RUN) && !fifo_empty;
        start_ok   = (state == IDLE) && start;
        pop        = sram_we && sram_ready;
        push_req   = (state == RUN) && res_valid && (rows_in < num_q);
        // A push into a full FIFO still fits when the head leaves this cycle.
        push       = push_req && (!fifo_full || pop);
        drop       = push_req && fifo_full && !pop;
        addr_sum   = SUM_W'(base_q) + SUM_W'(rows_written);
        sram_addr  = addr_sum[ADDRESSSIZE-1:0];
        sram_wdata = mem[rd_ptr];
    end

    // ---------------- transfer bookkeeping ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            base_q       <= '0;
            num_q        <= '0;
            rows_in      <= '0;
            rows_written <= '0;
            overflow     <= 1'b0;
        end else if (start_ok) begin
            base_q       <= base_addr;
            num_q        <= num_rows;
            rows_in      <= '0;
            rows_written <= '0;
            overflow     <= 1'b0;
        end else begin
            if (push) rows_in      <= rows_in + ROWCNT_BW'(1);
            if (pop)  rows_written <= rows_written + ROWCNT_BW'(1);
            if (drop) overflow     <= 1'b1;
        end
    end

    // ---------------- FIFO ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (start_ok) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= res_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_result_writeback.sv
module tb_result_writeback;

    localparam int AW = 10;
    localparam int MS = 16;
    localparam int PB = 24;
    localparam int RB = 11;
    localparam int DW = PB * MS;

    logic          clk = 1'b0;
    logic          rstn;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [RB-1:0] num_rows;
    logic          res_valid;
    logic [DW-1:0] res_data;
    logic          sram_ready;
    logic          sram_we;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic          busy;
    logic          done;
    logic          overflow;
    logic [RB-1:0] rows_written;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    result_writeback #(
        .ADDRESSSIZE   (AW),
        .MATRIX_SIZE   (MS),
        .PARTIAL_SUM_BW(PB),
        .FIFO_DEPTH    (4),
        .ROWCNT_BW     (RB)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .start       (start),
        .base_addr   (base_addr),
        .num_rows    (num_rows),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .sram_ready  (sram_ready),
        .sram_we     (sram_we),
        .sram_addr   (sram_addr),
        .sram_wdata  (sram_wdata),
        .busy        (busy),
        .done        (done),
        .overflow    (overflow),
        .rows_written(rows_written)
    );

    // Distinct per-lane pattern tagged with the row value; odd lanes carry the MSB.
    function automatic logic [DW-1:0] mk(input int unsigned v);
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < MS; i++)
            r[i*PB +: PB] = PB'((v << 12) | i) ^ ((i % 2 == 1) ? 24'h800000 : 24'h000000);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_wr(input string nm, input logic [AW-1:0] a, input int unsigned v);
        chk({nm, "_we"}, DW'(sram_we), DW'(1'b1));
        chk({nm, "_addr"}, DW'(sram_addr), DW'(a));
        chk({nm, "_data"}, sram_wdata, mk(v));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 1'b0; base_addr = '0; num_rows = '0;
        res_valid = 1'b0; res_data = '0; sram_ready = 1'b1;
    endtask

    typedef struct {
        logic          start;
        logic [AW-1:0] base;
        logic [RB-1:0] num;
        logic          rv;
        int unsigned   lane_v;
        logic          rdy;
        logic          e_we;
        logic [AW-1:0] e_addr;
        int unsigned   e_v;
        logic          e_busy;
        logic          e_done;
        logic          e_ovf;
        logic [RB-1:0] e_rw;
    } vec_t;

    vec_t tbl[23];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // start  base    num rv  v rdy  we addr     ev busy done ovf rw
        tbl[0]  = '{1, 10'h010, 4, 0, 0, 1, 0, 10'h000, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 10'h000, 0, 1, 1, 1, 0, 10'h010, 0, 1, 0, 0, 0};
        tbl[2]  = '{0, 10'h000, 0, 1, 2, 1, 1, 10'h010, 1, 1, 0, 0, 0};
        tbl[3]  = '{0, 10'h000, 0, 1, 3, 1, 1, 10'h011, 2, 1, 0, 0, 1};
        tbl[4]  = '{0, 10'h000, 0, 1, 4, 1, 1, 10'h012, 3, 1, 0, 0, 2};
        tbl[5]  = '{0, 10'h000, 0, 0, 0, 1, 1, 10'h013, 4, 1, 0, 0, 3};
        tbl[6]  = '{1, 10'h055, 2, 0, 0, 1, 0, 10'h014, 0, 0, 1, 0, 4};  // start in FIN ignored
        tbl[7]  = '{1, 10'h020, 0, 0, 0, 1, 0, 10'h014, 0, 0, 0, 0, 4};  // num_rows=0
        tbl[8]  = '{0, 10'h000, 0, 0, 0, 1, 0, 10'h020, 0, 0, 1, 0, 0};
        tbl[9]  = '{1, 10'h3FE, 4, 1, 9, 1, 0, 10'h020, 0, 0, 0, 0, 0};  // res_valid in IDLE ignored
        tbl[10] = '{0, 10'h000, 0, 1, 5, 1, 0, 10'h3FE, 0, 1, 0, 0, 0};
        tbl[11] = '{0, 10'h000, 0, 1, 6, 1, 1, 10'h3FE, 5, 1, 0, 0, 0};
        tbl[12] = '{0, 10'h000, 0, 1, 7, 1, 1, 10'h3FF, 6, 1, 0, 0, 1};
        tbl[13] = '{0, 10'h000, 0, 1, 8, 1, 1, 10'h000, 7, 1, 0, 0, 2};
        tbl[14] = '{0, 10'h000, 0, 0, 0, 1, 1, 10'h001, 8, 1, 0, 0, 3};
        tbl[15] = '{0, 10'h000, 0, 0, 0, 1, 0, 10'h002, 0, 0, 1, 0, 4};
        tbl[16] = '{1, 10'h100, 3, 0, 0, 1, 0, 10'h002, 0, 0, 0, 0, 4};
        tbl[17] = '{1, 10'h200, 7, 1, 1, 1, 0, 10'h100, 0, 1, 0, 0, 0};  // start in RUN ignored
        tbl[18] = '{0, 10'h000, 0, 1, 2, 1, 1, 10'h100, 1, 1, 0, 0, 0};
        tbl[19] = '{1, 10'h200, 7, 1, 3, 1, 1, 10'h101, 2, 1, 0, 0, 1};
        tbl[20] = '{0, 10'h000, 0, 1, 4, 1, 1, 10'h102, 3, 1, 0, 0, 2};  // beyond num_rows
        tbl[21] = '{0, 10'h000, 0, 1, 5, 1, 0, 10'h103, 0, 0, 1, 0, 3};
        tbl[22] = '{0, 10'h000, 0, 1, 6, 1, 0, 10'h103, 0, 0, 0, 0, 3};

        // ---- reset state ----
        idle_inputs();
        rstn = 1'b0;
        #12;
        chk("rst_we", DW'(sram_we), '0);
        chk("rst_addr", DW'(sram_addr), '0);
        chk("rst_wdata", sram_wdata, '0);
        chk("rst_busy", DW'(busy), '0);
        chk("rst_done", DW'(done), '0);
        chk("rst_ovf", DW'(overflow), '0);
        chk("rst_rw", DW'(rows_written), '0);
        rstn = 1'b1;
        tick();

        // ---- table-driven vectors ----
        for (int i = 0; i < 23; i++) begin
            start = tbl[i].start; base_addr = tbl[i].base; num_rows = tbl[i].num;
            res_valid = tbl[i].rv; res_data = mk(tbl[i].lane_v); sram_ready = tbl[i].rdy;
            @(negedge clk);
            chk($sformatf("v%0d_we", i), DW'(sram_we), DW'(tbl[i].e_we));
            chk($sformatf("v%0d_addr", i), DW'(sram_addr), DW'(tbl[i].e_addr));
            if (tbl[i].e_we) chk($sformatf("v%0d_data", i), sram_wdata, mk(tbl[i].e_v));
            chk($sformatf("v%0d_busy", i), DW'(busy), DW'(tbl[i].e_busy));
            chk($sformatf("v%0d_done", i), DW'(done), DW'(tbl[i].e_done));
            chk($sformatf("v%0d_ovf", i), DW'(overflow), DW'(tbl[i].e_ovf));
            chk($sformatf("v%0d_rw", i), DW'(rows_written), DW'(tbl[i].e_rw));
            tick();
        end
        idle_inputs();
        tick();

        // ---- backpressure: 6 results into depth 4 with ready low ----
        start = 1'b1; base_addr = 10'h040; num_rows = 6; sram_ready = 1'b0;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            res_valid = 1'b1; res_data = mk(i);
            @(negedge clk);
            if (i >= 2) chk_wr($sformatf("bp_hold%0d", i), 10'h040, 1);
            tick();
        end
        res_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_wr($sformatf("bp_stall%0d", i), 10'h040, 1);
            chk($sformatf("bp_ovf%0d", i), DW'(overflow), DW'(1'b1));
            tick();
        end
        sram_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk_wr($sformatf("bp_wr%0d", k), AW'(10'h040 + k), k + 1);
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("bp_wait_we%0d", k), DW'(sram_we), '0);
            chk($sformatf("bp_wait_done%0d", k), DW'(done), '0);
            chk($sformatf("bp_wait_busy%0d", k), DW'(busy), DW'(1'b1));
            chk($sformatf("bp_wait_rw%0d", k), DW'(rows_written), DW'(4));
            tick();
        end
        res_valid = 1'b1; res_data = mk(7);
        tick();
        res_data = mk(8);
        @(negedge clk);
        chk_wr("bp_wr4", 10'h044, 7);
        tick();
        res_valid = 1'b0;
        @(negedge clk);
        chk_wr("bp_wr5", 10'h045, 8);
        tick();
        @(negedge clk);
        chk("bp_done", DW'(done), DW'(1'b1));
        chk("bp_rw", DW'(rows_written), DW'(6));
        chk("bp_ovf_sticky", DW'(overflow), DW'(1'b1));
        tick();
        @(negedge clk);
        chk("bp_done_pulse", DW'(done), '0);
        tick();

        // ---- full FIFO with simultaneous push and pop ----
        start = 1'b1; base_addr = 10'h080; num_rows = 8; sram_ready = 1'b0;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            res_valid = 1'b1; res_data = mk(i);
            tick();
        end
        sram_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            res_valid = (k < 4); res_data = mk(k + 5);
            @(negedge clk);
            chk_wr($sformatf("fp_wr%0d", k), AW'(10'h080 + k), k + 1);
            chk($sformatf("fp_ovf%0d", k), DW'(overflow), '0);
            tick();
        end
        res_valid = 1'b0;
        @(negedge clk);
        chk("fp_done", DW'(done), DW'(1'b1));
        chk("fp_rw", DW'(rows_written), DW'(8));
        chk("fp_ovf_end", DW'(overflow), '0);
        tick();

        // ---- reset mid-RUN after 2 of 5 writes ----
        start = 1'b1; base_addr = 10'h0C0; num_rows = 5; sram_ready = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            res_valid = 1'b1; res_data = mk(i);
            @(negedge clk);
            if (i >= 2) chk_wr($sformatf("mr_wr%0d", i), AW'(10'h0C0 + i - 2), i - 1);
            if (i < 4) tick();
        end
        chk("mr_rw_before", DW'(rows_written), DW'(2));
        #2 rstn = 1'b0;
        #1;
        chk("mr_we", DW'(sram_we), '0);
        chk("mr_addr", DW'(sram_addr), '0);
        chk("mr_wdata", sram_wdata, '0);
        chk("mr_busy", DW'(busy), '0);
        chk("mr_done", DW'(done), '0);
        chk("mr_ovf", DW'(overflow), '0);
        chk("mr_rw", DW'(rows_written), '0);
        idle_inputs();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk($sformatf("mr_hold_done%0d", k), DW'(done), '0);
        end
        rstn = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk($sformatf("mr_post_done%0d", k), DW'(done), '0);
            chk($sformatf("mr_post_we%0d", k), DW'(sram_we), '0);
        end
        tick();
        start = 1'b1; base_addr = 10'h0D0; num_rows = 2;
        tick();
        start = 1'b0;
        res_valid = 1'b1; res_data = mk(11);
        tick();
        res_data = mk(12);
        @(negedge clk);
        chk_wr("rr_wr0", 10'h0D0, 11);
        tick();
        res_valid = 1'b0;
        @(negedge clk);
        chk_wr("rr_wr1", 10'h0D1, 12);
        tick();
        @(negedge clk);
        chk("rr_done", DW'(done), DW'(1'b1));
        chk("rr_rw", DW'(rows_written), DW'(2));
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
